vram_write_arbiter: RTL
=======================

Name: vram_write_arbiter

Overview:
Shares the single HDMI VRAM write port between two requesters: port 0 is the CPU store path and port 1 is the pattern/test generator. It also contains a built-in clear engine that fills the whole frame with one value. It sits between the requesters and the VRAM port of the HDMI controller (sel/addr/we/qin) and runs in the pixel clock domain. The block issues at most one VRAM write per cycle and drives registered outputs.

Parameters:
VRAM_BASE, 32'h0020_0000, byte address of the first VRAM location
VRAM_DEPTH, 57600, number of addressable VRAM locations
XLEN, 32, data width of qin

Ports:
clk  input  1  pixel/logic clock
rst_n  input  1  asynchronous active-low reset
req0  input  1  port 0 (CPU) write request, held until ack0
addr0  input  32  port 0 byte address
we0  input  3  port 0 write-enable code, forwarded unchanged
data0  input  XLEN  port 0 write data
ack0  output  1  one-cycle pulse: port 0 request consumed
err0  output  1  one-cycle pulse with ack0 when addr0 was out of range
req1, addr1, we1, data1, ack1, err1  same as port 0, for port 1 (pattern generator)
clear_start  input  1  pulse: start a full-frame clear
clear_value  input  8  byte written to every location during a clear
clear_busy  output  1  high while the clear engine owns the port
clear_done  output  1  one-cycle pulse after the last clear write
vram_sel  output  1  VRAM select, high only on an issued in-range write
vram_addr  output  32  VRAM address
vram_we  output  3  VRAM write-enable code; 3'b000 when idle
vram_qin  output  XLEN  VRAM write data

Behaviour:
- Reset (async, rst_n=0) values:
  - all outputs 0 (vram_*, ack*, err*, clear_busy, clear_done)
  - FSM state = IDLE
  - last_grant = 1, so port 0 wins the first tie
- FSM states: IDLE, CLEAR.
- IDLE, per cycle, in priority order:
  - clear_start=1 -> go to CLEAR; no grant is issued this cycle.
  - Otherwise, if exactly one req is high, grant that port.
  - If both are high, grant the port that is not last_grant (round-robin), then update last_grant.
- Grant in cycle N:
  - ackX=1 in cycle N+1.
  - Outputs registered in N+1: vram_addr=addrX, vram_we=weX, vram_qin=dataX.
  - vram_sel=1 in N+1 only if VRAM_BASE <= addrX <= VRAM_BASE+VRAM_DEPTH-1. Otherwise vram_sel=0, vram_we=3'b000, and errX=1 together with ackX.
  - Latency from request to VRAM write is 1 cycle.
- Requester rules:
  - A requester samples ack and may present a new request, or drop req, in the cycle after ack.
  - The arbiter must not grant the same port in the cycle its ack is high, because that req is stale. The maximum rate per port is therefore one write every 2 cycles.
  - The other port may be granted back-to-back, so the VRAM port can be written every cycle.
- Cycles with no grant: vram_sel=0, vram_we=3'b000; vram_addr and vram_qin hold their previous values.
- CLEAR:
  - clear_busy=1 from the cycle after clear_start until the cycle of clear_done, inclusive.
  - clear_value is latched at clear_start.
  - Issues VRAM_DEPTH consecutive writes, one per cycle, at addresses VRAM_BASE .. VRAM_BASE+VRAM_DEPTH-1.
  - Each write uses vram_sel=1, vram_we=3'b100, vram_qin={(XLEN-8)'b0, value}.
  - clear_done pulses 1 cycle after the final write, then the FSM returns to IDLE.
  - No acks are issued while in CLEAR; requests stay pending and are served after return, using the normal round-robin.
  - clear_start while clear_busy=1 is ignored.
  - Internal counter: 16 bits, runs 0..VRAM_DEPTH-1; the last write is at count VRAM_DEPTH-1 and the count does not wrap.
- An address compare that overflows is treated as out of range: the sum is computed at 33 bits.
- Reset mid-clear: everything returns to the reset values immediately; the clear is not resumed.

Optional Feature:
VRAM_ARB_FIXED_PRIO_EN
- Defined: port 0 has strict priority. When both ports request, port 0 always wins and last_grant is unused. Port 1 is served only in cycles where req0=0, or in the cycle where ack0=1, which is port 0's mandatory idle cycle.
- Undefined: round-robin as described in Behaviour.

Test Plan:
1. Single write: req0 with addr=32'h0020_0010, data=32'h55, we=3'b100 -> ack0 one cycle later; in the same cycle vram_sel=1, vram_addr=32'h0020_0010, vram_qin=32'h55, err0=0.
2. Out-of-range write: req1 with addr=32'h0020_E100 (BASE+57600) -> ack1=1 and err1=1 in the same cycle; vram_sel=0, vram_we=3'b000.
3. Round-robin: req0 and req1 held continuously for 8 writes -> grant order 0,1,0,1,...; vram_sel is high every cycle after the first; each ack is spaced 2 cycles apart.
4. Clear: clear_start with clear_value=8'h7F -> 57600 consecutive writes at 32'h0020_0000..32'h0020_E0FF, each with qin=32'h7F; clear_done one cycle after the last write; clear_busy high throughout.
5. Contention with clear: req0 raised mid-clear -> no ack0 until clear_done; ack0 arrives within 2 cycles after clear_done; a second clear_start mid-clear has no effect (total write count stays 57600).
6. Async reset mid-clear: rst_n=0 at write 1000 -> all outputs go to 0 without waiting for a clock edge; after release the FSM is in IDLE and a new req0 is served normally. Re-run scenario 3 with VRAM_ARB_FIXED_PRIO_EN defined -> port 1 is granted only in ack0 cycles.

Source files
------------

// File: rtl/vram_write_arbiter_if.sv
// Bundle of requester, clear-engine and VRAM-port signals for vram_write_arbiter.
// master = requester/controller side, slave = the arbiter.
interface vram_write_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req0;
    logic [31:0]     addr0;
    logic [2:0]      we0;
    logic [XLEN-1:0] data0;
    logic            ack0;
    logic            err0;

    logic            req1;
    logic [31:0]     addr1;
    logic [2:0]      we1;
    logic [XLEN-1:0] data1;
    logic            ack1;
    logic            err1;

    logic            clear_start;
    logic [7:0]      clear_value;
    logic            clear_busy;
    logic            clear_done;

    logic            vram_sel;
    logic [31:0]     vram_addr;
    logic [2:0]      vram_we;
    logic [XLEN-1:0] vram_qin;

    modport master (
        output req0, addr0, we0, data0,
        output req1, addr1, we1, data1,
        output clear_start, clear_value,
        input  ack0, err0, ack1, err1,
        input  clear_busy, clear_done,
        input  vram_sel, vram_addr, vram_we, vram_qin
    );

    modport slave (
        input  req0, addr0, we0, data0,
        input  req1, addr1, we1, data1,
        input  clear_start, clear_value,
        output ack0, err0, ack1, err1,
        output clear_busy, clear_done,
        output vram_sel, vram_addr, vram_we, vram_qin
    );
endinterface

// File: rtl/vram_write_arbiter.sv
// Two-port VRAM write arbiter with a full-frame clear engine; all outputs registered.
// Optional macro VRAM_ARB_FIXED_PRIO_EN: port 0 strict priority instead of round-robin.
module vram_write_arbiter #(
    parameter logic [31:0] VRAM_BASE  = 32'h0020_0000,
    parameter int          VRAM_DEPTH = 57600,
    parameter int          XLEN       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vram_write_arbiter_if.slave  bus
);
    localparam logic [32:0] ADDR_LO  = {1'b0, VRAM_BASE};
    localparam logic [32:0] ADDR_HI  = {1'b0, VRAM_BASE} + 33'(VRAM_DEPTH) - 33'd1;
    localparam logic [15:0] CNT_LAST = 16'(VRAM_DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // 33-bit compare so an address near 2^32 cannot wrap into range
    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= ADDR_LO) && ({1'b0, a} <= ADDR_HI);
    endfunction

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            drain_q, drain_d;
    logic [7:0]      val_q, val_d;
    logic            ack0_q, ack0_d, err0_q, err0_d;
    logic            ack1_q, ack1_d, err1_q, err1_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            sel_q, sel_d;
    logic [2:0]      we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [XLEN-1:0] qin_q, qin_d;
    logic            elig0_s, elig1_s, grant0_s, grant1_s;

    // Next-state and next-output logic for arbitration and the clear engine
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        val_d    = val_q;
        ack0_d   = 1'b0;
        err0_d   = 1'b0;
        ack1_d   = 1'b0;
        err1_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sel_d    = 1'b0;
        we_d     = 3'b000;
        addr_d   = addr_q;
        qin_d    = qin_q;
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        // a request whose ack is on the wire this cycle is stale
        elig0_s  = bus.req0 & ~ack0_q;
        elig1_s  = bus.req1 & ~ack1_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.clear_start && !busy_q) begin
                    state_d = ST_CLEAR;
                    busy_d  = 1'b1;
                    cnt_d   = 16'd0;
                    drain_d = 1'b0;
                    val_d   = bus.clear_value;
                end else begin
`ifdef VRAM_ARB_FIXED_PRIO_EN
                    grant0_s = elig0_s;
                    grant1_s = ~elig0_s & elig1_s;
`else
                    if (elig0_s && elig1_s) begin
                        grant0_s = last_q;
                        grant1_s = ~last_q;
                    end else begin
                        grant0_s = elig0_s;
                        grant1_s = elig1_s;
                    end
`endif
                end

                if (grant0_s) begin
                    last_d = 1'b0;
                    ack0_d = 1'b1;
                    addr_d = bus.addr0;
                    qin_d  = bus.data0;
                    if (in_range(bus.addr0)) begin
                        sel_d = 1'b1;
                        we_d  = bus.we0;
                    end else begin
                        err0_d = 1'b1;
                    end
                end else if (grant1_s) begin
                    last_d = 1'b1;
                    ack1_d = 1'b1;
                    addr_d = bus.addr1;
                    qin_d  = bus.data1;
                    if (in_range(bus.addr1)) begin
                        sel_d = 1'b1;
                        we_d  = bus.we1;
                    end else begin
                        err1_d = 1'b1;
                    end
                end else begin
                    last_d = last_q;
                end
            end

            ST_CLEAR: begin
                // drain_q marks the cycle after the final write: pulse done and leave
                if (drain_q) begin
                    done_d  = 1'b1;
                    drain_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    sel_d  = 1'b1;
                    we_d   = 3'b100;
                    addr_d = VRAM_BASE + {16'd0, cnt_q};
                    qin_d  = {{(XLEN-8){1'b0}}, val_q};
                    if (cnt_q == CNT_LAST) begin
                        drain_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
            drain_q <= 1'b0;
            val_q   <= 8'd0;
            ack0_q  <= 1'b0;
            err0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err1_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= 1'b0;
            we_q    <= 3'b000;
            addr_q  <= 32'd0;
            qin_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            val_q   <= val_d;
            ack0_q  <= ack0_d;
            err0_q  <= err0_d;
            ack1_q  <= ack1_d;
            err1_q  <= err1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            qin_q   <= qin_d;
        end
    end

    assign bus.ack0       = ack0_q;
    assign bus.err0       = err0_q;
    assign bus.ack1       = ack1_q;
    assign bus.err1       = err1_q;
    assign bus.clear_busy = busy_q;
    assign bus.clear_done = done_q;
    assign bus.vram_sel   = sel_q;
    assign bus.vram_we    = we_q;
    assign bus.vram_addr  = addr_q;
    assign bus.vram_qin   = qin_q;
endmodule
